// File: rtl/rf_seq_pkg.sv
// Shared types and instruction field layout for the register-file sequencer.
package rf_seq_pkg;

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned OPC_LSB = 9;
  localparam int unsigned WA_LSB  = 6;
  localparam int unsigned AD1_LSB = 3;
  localparam int unsigned AD2_LSB = 0;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MOV = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU: 4-bit wrap arithmetic/logic with carry (borrow on SUB) and zero.
module rf_alu
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  opcode_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of the difference is the unsigned borrow.
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rf_sequencer.sv
// Multi-cycle sequencer driving the 8x4 register file, with manual-record arbitration.
module rf_sequencer
  import rf_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OPC_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [OPC_W+3*ADDR_W-1:0] instr,
  input  logic                      rec_req,
  output logic                      record,
  output logic [ADDR_W-1:0]         RF_ad1,
  output logic [ADDR_W-1:0]         RF_ad2,
  output logic [ADDR_W-1:0]         RF_wa,
  output logic                      RF_we,
  output logic [DATA_W-1:0]         RF_wd,
  input  logic [DATA_W-1:0]         RF_d1,
  input  logic [DATA_W-1:0]         RF_d2,
  output logic                      busy,
  output logic                      done,
  output logic                      zero_flag,
  output logic                      carry_flag
);

  localparam int unsigned IW = OPC_W + 3*ADDR_W;

  state_e            state_q, state_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic              pend_q, pend_d;
  logic              rec_prev_q;
  logic              rec_rise;

  opcode_e           op_q;
  opcode_e           op_in;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  logic              alu_zero;

  assign op_q     = opcode_e'(instr_q[OPC_LSB +: OPC_W]);
  assign op_in    = opcode_e'(instr[OPC_LSB +: OPC_W]);
  assign rec_rise = rec_req & ~rec_prev_q;

  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (RF_d1),
    .b      (RF_d2),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    pend_d      = pend_q | rec_rise;
    record      = 1'b0;
    instr_ready = 1'b0;
    RF_we       = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A pending manual record owns this idle cycle ahead of any instruction.
        if (pend_q) begin
          record = 1'b1;
          pend_d = rec_rise;
        end else begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            instr_d = instr;
            case (op_in)
              OP_NOP:  state_d = S_DONE;
              OP_LDI:  state_d = S_WRITE;
              default: state_d = S_READ;
            endcase
          end
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC: begin
        result_d = alu_res;
        if (op_q inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR}) begin
          zero_d  = alu_zero;
          carry_d = alu_carry;
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        RF_we   = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      pend_q     <= 1'b0;
      rec_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      pend_q     <= pend_d;
      rec_prev_q <= rec_req;
    end
  end

  assign RF_ad1     = instr_q[AD1_LSB +: ADDR_W];
  assign RF_ad2     = instr_q[AD2_LSB +: ADDR_W];
  assign RF_wa      = instr_q[WA_LSB +: ADDR_W];
  assign RF_wd      = (state_q == S_WRITE && op_q == OP_LDI) ? instr_q[IMM_LSB +: DATA_W] : result_q;
  assign busy       = (state_q != S_IDLE);
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Bench for rf_sequencer: behavioural register file plus a latency-table reference model.
module tb_rf_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic        rec_req;
  logic        record;
  logic [2:0]  RF_ad1, RF_ad2, RF_wa;
  logic        RF_we;
  logic [3:0]  RF_wd;
  logic [3:0]  rd1_q, rd2_q;
  logic        busy, done, zero_flag, carry_flag;

  always #5 clk = ~clk;

  rf_sequencer #(.DATA_W(4), .ADDR_W(3), .OPC_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .rec_req     (rec_req),
    .record      (record),
    .RF_ad1      (RF_ad1),
    .RF_ad2      (RF_ad2),
    .RF_wa       (RF_wa),
    .RF_we       (RF_we),
    .RF_wd       (RF_wd),
    .RF_d1       (rd1_q),
    .RF_d2       (rd2_q),
    .busy        (busy),
    .done        (done),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag)
  );

  logic       rf_load;
  logic [3:0] rf [8];

  always @(posedge clk) begin
    if (rf_load) begin
      rf[0] <= 4'd6; rf[1] <= 4'd3; rf[2] <= 4'd2; rf[3] <= 4'd3;
      rf[4] <= 4'd4; rf[5] <= 4'd5; rf[6] <= 4'd6; rf[7] <= 4'd7;
    end else if (RF_we) begin
      rf[RF_wa] <= RF_wd;
    end
    rd1_q <= rf[RF_ad1];
    rd2_q <= rf[RF_ad2];
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: register contents, flags, and position within the current instruction.
  logic [3:0] mreg [8];
  int         m_cyc, m_lat;
  logic [2:0] m_op, m_wa, m_a1, m_a2;
  logic [3:0] m_wd;
  logic       m_fl, m_nz, m_nc, m_z, m_c, m_pend, m_recp, m_acc;
  int         cyc_n, acc_cyc, done_cyc, rec_cnt, we_cnt, done_cnt;
  logic [3:0] last_wd;
  logic [2:0] last_wa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept_model(input logic [11:0] ins);
    int a, b, t;
    m_acc   = 1'b1;
    acc_cyc = cyc_n;
    m_op = ins[11:9]; m_wa = ins[8:6]; m_a1 = ins[5:3]; m_a2 = ins[2:0];
    a = int'(mreg[m_a1]);
    b = int'(mreg[m_a2]);
    m_fl = 1'b0; m_nc = 1'b0; m_wd = 4'd0; m_cyc = 1; m_lat = 4;
    case (m_op)
      3'd0: m_lat = 1;
      3'd1: begin m_lat = 2; m_wd = ins[3:0]; end
      3'd2: begin t = a + b; m_wd = 4'(t % 16); m_nc = (t > 15); m_fl = 1'b1; end
      3'd3: begin t = a - b; m_wd = 4'((t + 16) % 16); m_nc = (t < 0); m_fl = 1'b1; end
      3'd4: begin m_wd = 4'(a & b); m_fl = 1'b1; end
      3'd5: begin m_wd = 4'(a | b); m_fl = 1'b1; end
      3'd6: begin m_wd = 4'(a ^ b); m_fl = 1'b1; end
      default: m_wd = 4'(a);
    endcase
    m_nz = (m_wd == 4'd0);
  endtask

  task automatic tick();
    logic idle, e_we, rise;
    idle = (m_cyc == 0);
    e_we = !idle && (m_op != 3'd0) && (m_cyc == m_lat - 1);
    chk("ctl", 32'({busy, done, RF_we, record, instr_ready}),
        32'({!idle, !idle && (m_cyc == m_lat), e_we, idle && m_pend, idle && !m_pend}));
    chk("flags", 32'({zero_flag, carry_flag}), 32'({m_z, m_c}));
    if (e_we) begin
      chk("wa", 32'(RF_wa), 32'(m_wa));
      chk("wd", 32'(RF_wd), 32'(m_wd));
      last_wd = RF_wd;
      last_wa = RF_wa;
    end
    if (!idle && m_cyc == 1 && m_op >= 3'd2) begin
      chk("ad1", 32'(RF_ad1), 32'(m_a1));
      chk("ad2", 32'(RF_ad2), 32'(m_a2));
    end
    if (done) begin done_cyc = cyc_n; done_cnt++; end
    if (record) rec_cnt++;
    if (RF_we) we_cnt++;
    if (e_we) mreg[m_wa] = m_wd;
    m_acc = 1'b0;
    if (rst) begin
      m_cyc = 0; m_lat = 0; m_pend = 1'b0; m_recp = 1'b0;
      m_z = 1'b0; m_c = 1'b0; m_op = 3'd0;
    end else begin
      rise   = rec_req && !m_recp;
      m_recp = rec_req;
      if (!idle) begin
        if (m_cyc == 2 && m_fl) begin m_z = m_nz; m_c = m_nc; end
        m_cyc++;
        if (m_cyc > m_lat) m_cyc = 0;
        m_pend = m_pend || rise;
      end else if (m_pend) begin
        m_pend = rise;
      end else begin
        m_pend = rise;
        if (instr_valid) accept_model(instr);
      end
    end
    cyc_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [11:0] ins);
    int n = 0;
    instr_valid = 1'b1;
    instr       = ins;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 40);
    instr_valid = 1'b0;
    chk("accept_timeout", 32'(m_acc), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int r0, w0, d0, rc;
    rst = 1'b1; instr_valid = 1'b0; instr = '0; rec_req = 1'b0; rf_load = 1'b1;
    mreg[0] = 4'd6; mreg[1] = 4'd3; mreg[2] = 4'd2; mreg[3] = 4'd3;
    mreg[4] = 4'd4; mreg[5] = 4'd5; mreg[6] = 4'd6; mreg[7] = 4'd7;
    m_cyc = 0; m_lat = 0; m_op = '0; m_wa = '0; m_a1 = '0; m_a2 = '0; m_wd = '0;
    m_fl = 0; m_nz = 0; m_nc = 0; m_z = 0; m_c = 0; m_pend = 0; m_recp = 0; m_acc = 0;
    cyc_n = 0; acc_cyc = 0; done_cyc = 0; rec_cnt = 0; we_cnt = 0; done_cnt = 0;
    last_wd = '0; last_wa = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rf_load = 1'b0;

    chk("rst_ctl",   32'({busy, done, RF_we, record}), 32'd0);
    chk("rst_addr",  32'({RF_ad1, RF_ad2, RF_wa}), 32'd0);
    chk("rst_wd",    32'(RF_wd), 32'd0);
    chk("rst_flags", 32'({zero_flag, carry_flag}), 32'd0);
    rst = 1'b0;
    tick();

    // ADD R4 = R1 + R2
    send(12'h50A); wait_idle();
    chk("add_wd", 32'(last_wd), 32'd5);
    chk("add_wa", 32'(last_wa), 32'd4);
    chk("add_lat", 32'(done_cyc - acc_cyc), 32'd4);
    chk("add_flags", 32'({zero_flag, carry_flag}), 32'b00);

    // LDI R0 = 0xF, then ADD R5 = R0 + R7 with carry
    send(12'h20F); wait_idle();
    chk("ldi_wd", 32'(last_wd), 32'hF);
    chk("ldi_lat", 32'(done_cyc - acc_cyc), 32'd2);
    send(12'h547); wait_idle();
    chk("addc_wd", 32'(last_wd), 32'd6);
    chk("addc_flags", 32'({zero_flag, carry_flag}), 32'b01);

    // SUB R3 = R2 - R1 (borrow), SUB R6 = R1 - R1 (zero)
    send(12'h6D1); wait_idle();
    chk("sub_wd", 32'(last_wd), 32'hF);
    chk("sub_flags", 32'({zero_flag, carry_flag}), 32'b01);
    send(12'h789); wait_idle();
    chk("subz_wd", 32'(last_wd), 32'd0);
    chk("subz_flags", 32'({zero_flag, carry_flag}), 32'b10);

    // NOP latency, then back-pressure on a second instruction while busy
    send(12'h000); wait_idle();
    chk("nop_lat", 32'(done_cyc - acc_cyc), 32'd1);
    send(12'h50A);
    send(12'hFE0);
    chk("bp_accept_after_done", 32'(acc_cyc - done_cyc), 32'd1);
    wait_idle();
    chk("mov_wd", 32'(last_wd), 32'd5);

    // Record pending in the idle cycle where an instruction waits
    r0 = rec_cnt;
    rec_req = 1'b1;
    tick();
    instr_valid = 1'b1; instr = 12'h289;
    chk("arb_record", 32'(record), 32'd1);
    chk("arb_ready", 32'(instr_ready), 32'd0);
    rc = cyc_n;
    send(12'h289);
    chk("arb_accept_next", 32'(acc_cyc - rc), 32'd1);
    wait_idle();
    repeat (4) tick();
    chk("arb_single_pulse", 32'(rec_cnt - r0), 32'd1);
    rec_req = 1'b0;
    tick();

    // Record raised while busy is serviced first in the next idle cycle
    send(12'h50A);
    rec_req = 1'b1; instr_valid = 1'b1; instr = 12'hFE0;
    begin
      int n = 0;
      while (!record && n < 20) begin tick(); n++; end
    end
    chk("arb2_record", 32'(record), 32'd1);
    rc = cyc_n;
    send(12'hFE0);
    chk("arb2_accept_next", 32'(acc_cyc - rc), 32'd1);
    wait_idle();
    rec_req = 1'b0;
    tick();

    // Reset during EXEC of ADD R1 = R0 + R7 aborts it
    send(12'h447);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_we", 32'(RF_we), 32'd0);
    chk("rstmid_flags", 32'({zero_flag, carry_flag}), 32'd0);
    w0 = we_cnt; d0 = done_cnt;
    repeat (6) tick();
    chk("rstmid_no_write", 32'(we_cnt - w0), 32'd0);
    chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstmid_r1_kept", 32'(rf[1]), 32'd3);

    // Randomised traffic with occasional record requests and resets
    repeat (500) begin
      rst         = ($urandom_range(149, 0) == 0);
      instr_valid = 1'($urandom);
      instr       = 12'($urandom);
      if ($urandom_range(11, 0) == 0) rec_req = ~rec_req;
      tick();
    end
    rst = 1'b0; instr_valid = 1'b0; rec_req = 1'b0;
    wait_idle();
    repeat (3) tick();
    for (int i = 0; i < 8; i++) chk("rf_final", 32'(rf[i]), 32'(mreg[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
